// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 window controller: FSM state encoding and kernel geometry.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int unsigned KERNEL_SIZE = 3;
   localparam int unsigned KERNEL_HALF = 1;

endpackage

// File: rtl/raster_counter.sv
// Raster-order column/row counter for one frame; flags the final pixel position.
module raster_counter
   import conv_pkg::*;
#(
   parameter int unsigned IMG_WIDHT  = 220,
   parameter int unsigned IMG_HEIGHT = 220,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             abort,
   output logic [CNT_W-1:0] row,
   output logic [CNT_W-1:0] col,
   output logic             last
);

   localparam logic [CNT_W-1:0] ColMax = CNT_W'(IMG_WIDHT - 1);
   localparam logic [CNT_W-1:0] RowMax = CNT_W'(IMG_HEIGHT - 1);

   assign last = (row == RowMax) && (col == ColMax);

   // The row never wraps: after the last pixel the counter parks until cleared.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row <= '0;
         col <= '0;
      end else if (abort || clr) begin
         row <= '0;
         col <= '0;
      end else if (en && !last) begin
         if (col == ColMax) begin
            col <= '0;
            row <= row + CNT_W'(1);
         end else begin
            col <= col + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/conv3x3_window_ctrl.sv
// Sequencing controller for a 3x3 window generator: accept/shift control, window qualification,
// centre coordinates and frame completion. Define CONV_STRIDE2_EN for stride-2 window output.
module conv3x3_window_ctrl
   import conv_pkg::*;
#(
   parameter int unsigned IMG_WIDHT  = 220,
   parameter int unsigned IMG_HEIGHT = 220,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             shift_en,
   input  logic             m_ready,
   output logic             win_valid,
   output logic [CNT_W-1:0] win_row,
   output logic [CNT_W-1:0] win_col,
   output logic [CNT_W-1:0] win_cnt,
   output logic             busy,
   output logic             frame_done
);

   localparam logic [CNT_W-1:0] EdgeMin = CNT_W'(KERNEL_SIZE - 1);

   state_e           state;
   logic [CNT_W-1:0] row;
   logic [CNT_W-1:0] col;
   logic             last;
   logic             consume;
   logic             clr;
   logic             qualify;
   logic [CNT_W-1:0] nxt_row;
   logic [CNT_W-1:0] nxt_col;

   assign consume  = win_valid && m_ready;
   // A held window freezes the taps, so no pixel may shift in until it is taken.
   assign s_ready  = (state == RUN) && (!win_valid || m_ready);
   assign shift_en = s_valid && s_ready;
   assign busy     = (state == RUN) || (state == DRAIN);
   assign clr      = (state == IDLE) && start;

   raster_counter #(
      .IMG_WIDHT  (IMG_WIDHT),
      .IMG_HEIGHT (IMG_HEIGHT),
      .CNT_W      (CNT_W)
   ) u_raster_counter (
      .clk   (clk),
      .rst   (rst),
      .en    (shift_en),
      .clr   (clr),
      .abort (abort),
      .row   (row),
      .col   (col),
      .last  (last)
   );

`ifdef CONV_STRIDE2_EN
   logic [CNT_W-1:0] row_off;
   logic [CNT_W-1:0] col_off;

   always_comb begin
      row_off = row - EdgeMin;
      col_off = col - EdgeMin;
      qualify = (row >= EdgeMin) && (col >= EdgeMin) && !row_off[0] && !col_off[0];
      nxt_row = row_off >> 1;
      nxt_col = col_off >> 1;
   end
`else
   // Pixels in the first two rows/columns would complete windows that straddle a row wrap
   // or hold stale taps from the previous frame.
   always_comb begin
      qualify = (row >= EdgeMin) && (col >= EdgeMin);
      nxt_row = row - CNT_W'(KERNEL_HALF);
      nxt_col = col - CNT_W'(KERNEL_HALF);
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         win_valid  <= 1'b0;
         win_row    <= '0;
         win_col    <= '0;
         win_cnt    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (abort) begin
            state     <= IDLE;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            win_cnt   <= '0;
         end else begin
            if (consume) begin
               win_cnt <= win_cnt + CNT_W'(1);
            end

            if (shift_en) begin
               win_valid <= qualify;
               if (qualify) begin
                  win_row <= nxt_row;
                  win_col <= nxt_col;
               end
            end else if (consume) begin
               win_valid <= 1'b0;
            end

            unique case (state)
               IDLE: begin
                  if (start) begin
                     state   <= RUN;
                     win_cnt <= '0;
                  end
               end
               RUN: begin
                  if (shift_en && last) begin
                     state <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (!win_valid || m_ready) begin
                     state      <= IDLE;
                     frame_done <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_conv3x3_window_ctrl.sv
// Self-checking bench for conv3x3_window_ctrl on a 5x4 frame against a raster-level window model.
module tb_conv3x3_window_ctrl;

   localparam int unsigned W  = 5;
   localparam int unsigned H  = 4;
   localparam int unsigned CW = 16;

`ifdef CONV_STRIDE2_EN
   localparam int ExpWins   = 2;
   localparam int ExpStalls = 0;
`else
   localparam int ExpWins   = 6;
   localparam int ExpStalls = 3;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic          s_valid;
   logic          s_ready;
   logic          shift_en;
   logic          m_ready;
   logic          win_valid;
   logic [CW-1:0] win_row;
   logic [CW-1:0] win_col;
   logic [CW-1:0] win_cnt;
   logic          busy;
   logic          frame_done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int r;
      int c;
   } win_t;

   win_t exp_q[$];

   always #5 clk = ~clk;

   conv3x3_window_ctrl #(
      .IMG_WIDHT  (W),
      .IMG_HEIGHT (H),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .shift_en   (shift_en),
      .m_ready    (m_ready),
      .win_valid  (win_valid),
      .win_row    (win_row),
      .win_col    (win_col),
      .win_cnt    (win_cnt),
      .busy       (busy),
      .frame_done (frame_done)
   );

   function automatic bit qualifies(input int r, input int c);
`ifdef CONV_STRIDE2_EN
      return (r >= 2) && (c >= 2) && ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
`else
      return (r >= 2) && (c >= 2);
`endif
   endfunction

   function automatic win_t centre(input int r, input int c);
      win_t w;
`ifdef CONV_STRIDE2_EN
      w.r = (r - 2) / 2;
      w.c = (c - 2) / 2;
`else
      w.r = r - 1;
      w.c = c - 1;
`endif
      return w;
   endfunction

   task automatic build_expected();
      exp_q.delete();
      for (int r = 0; r < int'(H); r++)
         for (int c = 0; c < int'(W); c++)
            if (qualifies(r, c)) exp_q.push_back(centre(r, c));
   endtask

   // Drives one frame and checks every cycle against the raster model.
   // mode: 0 all high, 1 random, 2 s_valid toggling, 3 three-cycle stall on window (1,2).
   task automatic run_frame(input int mode, input bit chain_in, input bit chain_out,
                            input string tag, output int consumed, output int stalls);
      int   acc = 0, idx = 0, cyc = 0, last_cons = -10;
      int   prev_r = 0, prev_c = 0;
      bit   prev_shift = 0, prev_stall = 0, prev_notrun = 0, prev_release = 0;
      bit   done = 0, running, exp_wv, exp_sr, exp_fd;
      logic [CW-1:0] pr_row = '0, pr_col = '0;
      win_t e;
      consumed = 0;
      stalls   = 0;
      build_expected();
      if (!chain_in) begin
         @(negedge clk);
         start = 1; abort = 0; s_valid = 0; m_ready = 1;
         #1;
         total++;
         if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_busy got=%0b want=0", tag, busy);
         end
      end
      while (!done && cyc < 300) begin
         @(negedge clk);
         start = 0;
         unique case (mode)
            1: begin
               s_valid = 1'($urandom_range(0, 1));
               m_ready = ($urandom_range(0, 3) != 0);
               if (!frame_done && $urandom_range(0, 9) == 0) start = 1;
            end
            2: begin
               s_valid = (cyc % 2 == 0);
               m_ready = 1;
            end
            3: begin
               s_valid = 1;
               m_ready = !(win_valid && win_row == CW'(1) && win_col == CW'(2) && stalls < 3);
            end
            default: begin
               s_valid = 1;
               m_ready = 1;
            end
         endcase
         if (chain_out && frame_done) start = 1;
         #1;
         if (win_valid && !m_ready) stalls++;
         running = (acc < int'(W * H));
         exp_wv  = prev_stall ? 1'b1 : (prev_shift && qualifies(prev_r, prev_c));
         exp_sr  = running && (!win_valid || m_ready);
         exp_fd  = prev_notrun && prev_release;

         total++;
         if (win_valid !== exp_wv) begin
            bad++;
            $display("FAIL %s win_valid cyc=%0d got=%0b want=%0b", tag, cyc, win_valid, exp_wv);
         end
         if (exp_wv) begin
            if (prev_stall) begin
               e.r = int'(pr_row);
               e.c = int'(pr_col);
            end else begin
               e = centre(prev_r, prev_c);
            end
            total++;
            if (win_row !== CW'(e.r) || win_col !== CW'(e.c)) begin
               bad++;
               $display("FAIL %s coords cyc=%0d got=(%0d,%0d) want=(%0d,%0d)", tag, cyc,
                        win_row, win_col, e.r, e.c);
            end
         end
         total++;
         if (s_ready !== exp_sr || shift_en !== (s_valid && exp_sr)) begin
            bad++;
            $display("FAIL %s ready cyc=%0d got s_ready=%0b shift_en=%0b want %0b/%0b", tag, cyc,
                     s_ready, shift_en, exp_sr, s_valid && exp_sr);
         end
         total++;
         if (win_cnt !== CW'(consumed)) begin
            bad++;
            $display("FAIL %s win_cnt cyc=%0d got=%0d want=%0d", tag, cyc, win_cnt, consumed);
         end
         total++;
         if (frame_done !== exp_fd) begin
            bad++;
            $display("FAIL %s frame_done cyc=%0d got=%0b want=%0b", tag, cyc, frame_done, exp_fd);
         end
         if (win_valid && m_ready) begin
            total++;
            if (idx >= exp_q.size()) begin
               bad++;
               $display("FAIL %s extra_window got=(%0d,%0d) want=none", tag, win_row, win_col);
            end else if (win_row !== CW'(exp_q[idx].r) || win_col !== CW'(exp_q[idx].c)) begin
               bad++;
               $display("FAIL %s window_order idx=%0d got=(%0d,%0d) want=(%0d,%0d)", tag, idx,
                        win_row, win_col, exp_q[idx].r, exp_q[idx].c);
            end
            idx++;
            consumed++;
            last_cons = cyc;
         end
         if (frame_done) begin
            done = 1;
            total++;
            if (idx != exp_q.size() || acc != int'(W * H)) begin
               bad++;
               $display("FAIL %s frame_end got windows=%0d pixels=%0d want %0d/%0d", tag, idx,
                        acc, exp_q.size(), W * H);
            end
`ifndef CONV_STRIDE2_EN
            total++;
            if (last_cons != cyc - 1) begin
               bad++;
               $display("FAIL %s done_latency got=%0d want=1", tag, cyc - last_cons);
            end
`endif
         end
         prev_shift = shift_en;
         if (shift_en) begin
            prev_r = acc / int'(W);
            prev_c = acc % int'(W);
            acc++;
         end
         prev_stall   = win_valid && !m_ready;
         pr_row       = win_row;
         pr_col       = win_col;
         prev_notrun  = !running;
         prev_release = !win_valid || m_ready;
         cyc++;
      end
      if (!done) begin
         bad++;
         total++;
         $display("FAIL %s timeout got=no_frame_done want=frame_done", tag);
      end else if (!chain_out) begin
         @(negedge clk);
         s_valid = 0;
         start   = 0;
         #1;
         total++;
         if (busy !== 1'b0 || win_cnt !== CW'(exp_q.size())) begin
            bad++;
            $display("FAIL %s after_frame got busy=%0b win_cnt=%0d want 0/%0d", tag, busy,
                     win_cnt, exp_q.size());
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      total++;
      if ({s_ready, shift_en, win_valid, busy, frame_done} !== 5'b0) begin
         bad++;
         $display("FAIL %s flags got=%05b want=00000", tag,
                  {s_ready, shift_en, win_valid, busy, frame_done});
      end
      total++;
      if (win_row !== '0 || win_col !== '0 || win_cnt !== '0) begin
         bad++;
         $display("FAIL %s counts got row=%0d col=%0d cnt=%0d want 0", tag, win_row, win_col,
                  win_cnt);
      end
   endtask

   task automatic test_reset();
      rst = 0; start = 0; abort = 0; s_valid = 1; m_ready = 1;
      #12;
      check_reset_values("reset");
      @(negedge clk);
      rst = 1;
   endtask

   task automatic test_basic();
      int n, st;
      run_frame(0, 0, 0, "basic", n, st);
      total++;
      if (n != ExpWins) begin
         bad++;
         $display("FAIL basic_count got=%0d want=%0d", n, ExpWins);
      end
   endtask

   task automatic test_stall();
      int n, st;
      run_frame(3, 0, 0, "stall", n, st);
      total++;
      if (n != ExpWins || st != ExpStalls) begin
         bad++;
         $display("FAIL stall_count got wins=%0d stalls=%0d want %0d/%0d", n, st, ExpWins,
                  ExpStalls);
      end
   endtask

   task automatic test_toggle();
      int n, st;
      run_frame(2, 0, 0, "toggle", n, st);
      total++;
      if (n != ExpWins) begin
         bad++;
         $display("FAIL toggle_count got=%0d want=%0d", n, ExpWins);
      end
   endtask

   task automatic test_abort();
      int acc = 0, n = 0, wins, st;
      @(negedge clk);
      start = 1; abort = 0; s_valid = 0; m_ready = 1;
      while (acc < 12 && n < 100) begin
         @(negedge clk);
         start = 0; s_valid = 1; m_ready = 1;
         #1;
         if (shift_en) acc++;
         n++;
      end
      @(negedge clk);
      s_valid = 0; abort = 1;
      @(negedge clk);
      abort = 0;
      #1;
      total++;
      if (busy !== 1'b0 || win_valid !== 1'b0 || win_cnt !== '0 || frame_done !== 1'b0) begin
         bad++;
         $display("FAIL abort_state got busy=%0b wv=%0b cnt=%0d fd=%0b want 0/0/0/0", busy,
                  win_valid, win_cnt, frame_done);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         total++;
         if (frame_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_quiet got fd=%0b busy=%0b want 0/0", frame_done, busy);
         end
      end
      run_frame(0, 0, 0, "post_abort", wins, st);
      total++;
      if (wins != ExpWins) begin
         bad++;
         $display("FAIL post_abort_count got=%0d want=%0d", wins, ExpWins);
      end
   endtask

   task automatic test_reset_mid();
      int wins, st;
      @(negedge clk);
      start = 1; s_valid = 0; m_ready = 1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         start = 0; s_valid = 1;
      end
      #2;
      rst = 0;
      #1;
      check_reset_values("reset_mid");
      @(negedge clk);
      rst = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         s_valid = 1;
         #1;
         total++;
         if (busy !== 1'b0 || s_ready !== 1'b0 || win_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_needs_start got busy=%0b s_ready=%0b wv=%0b want 0/0/0", busy,
                     s_ready, win_valid);
         end
      end
      run_frame(0, 0, 0, "post_reset", wins, st);
      total++;
      if (wins != ExpWins) begin
         bad++;
         $display("FAIL post_reset_count got=%0d want=%0d", wins, ExpWins);
      end
   endtask

   task automatic test_back_to_back();
      int n1, n2, st;
      run_frame(0, 0, 1, "b2b_first", n1, st);
      run_frame(1, 1, 0, "b2b_second", n2, st);
      total++;
      if (n1 != ExpWins || n2 != ExpWins) begin
         bad++;
         $display("FAIL b2b_count got=%0d,%0d want=%0d", n1, n2, ExpWins);
      end
   endtask

   task automatic test_random();
      int n, st;
      for (int i = 0; i < 5; i++) begin
         run_frame(1, 0, 0, "random", n, st);
         total++;
         if (n != ExpWins) begin
            bad++;
            $display("FAIL random_count got=%0d want=%0d", n, ExpWins);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_toggle();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
